// File: rtl/request_latch_x4.sv
// request_latch_x4: four-channel asynchronous request latch.
// Each raw request line is synchronized, optionally debounced, and edge
// detected. Every rising edge latches one pending request that the consumer
// acknowledges by index. A request that arrives while its channel is still
// pending, and is not being acknowledged in that cycle, raises a sticky
// overrun flag.
// Optional feature: define REQUEST_LATCH_DEBOUNCE_EN to add a per-channel
// stability filter between the synchronizer and the edge detector.
module request_latch_x4 #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_in,
  input  logic       ack,
  input  logic [1:0] ack_idx,
  input  logic       ovr_clr,
  output logic [3:0] x,
  output logic [3:0] overrun
);

  // Reject out-of-range configurations at elaboration time.
  if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_sync_stages
    $error("request_latch_x4: SYNC_STAGES must be in 2..4");
  end
  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > 15)) begin : g_bad_debounce
    $error("request_latch_x4: DEBOUNCE_CYCLES must be in 1..15");
  end

  // Synchronizer chain; index 0 samples the raw pins.
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sync_last;
  logic [3:0] edge_src;

  logic [3:0] prev_q;
  logic [3:0] rise;
  logic [3:0] ack_dec;
  logic [3:0] ack_hit;
  logic [3:0] ovr_evt;

  logic [3:0] pending_q;
  logic [3:0] pending_d;
  logic [3:0] overrun_q;
  logic [3:0] overrun_d;

  // Shift raw requests through the synchronizer flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= 4'b0000;
      end
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

`ifdef REQUEST_LATCH_DEBOUNCE_EN
  // The filter output only follows the synchronized line after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; the counter value
  // DB_LAST marks the cycle in which that run completes.
  localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       filt_q;
  logic [3:0]       filt_d;
  logic [3:0][3:0]  cnt_q;
  logic [3:0][3:0]  cnt_d;

  // Per-channel stability counter and filtered level update.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync_last[i] != filt_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          filt_d[i] = sync_last[i];
          cnt_d[i]  = 4'd0;
        end else begin
          cnt_d[i]  = cnt_q[i] + 4'd1;
        end
      end else begin
        cnt_d[i] = 4'd0;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q <= 4'b0000;
      cnt_q  <= '{4{4'd0}};
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign edge_src = filt_q;
`else
  assign edge_src = sync_last;
`endif

  // Remember the previous edge-detector input level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 4'b0000;
    end else begin
      prev_q <= edge_src;
    end
  end

  assign rise = edge_src & ~prev_q;

  // Decode the acknowledge index into a one-hot channel select.
  always_comb begin
    ack_dec = 4'b0000;
    if (ack) begin
      case (ack_idx)
        2'd0:    ack_dec = 4'b0001;
        2'd1:    ack_dec = 4'b0010;
        2'd2:    ack_dec = 4'b0100;
        2'd3:    ack_dec = 4'b1000;
        default: ack_dec = 4'b0000;
      endcase
    end else begin
      ack_dec = 4'b0000;
    end
  end

  // An ack only matters for a channel that actually holds a request.
  assign ack_hit = ack_dec & pending_q;

  // Overrun: a new edge lands on a still-pending channel that is not being
  // acknowledged this cycle. A same-cycle ack simply hands the slot over.
  assign ovr_evt = rise & pending_q & ~ack_dec;

  // Pending set/clear: a new rise takes precedence over a same-cycle ack.
  always_comb begin
    pending_d = pending_q;
    pending_d = rise | (pending_q & ~ack_hit);
  end

  // Sticky overrun flags; a fresh event beats a simultaneous clear.
  always_comb begin
    overrun_d = overrun_q;
    if (ovr_clr) begin
      overrun_d = ovr_evt;
    end else begin
      overrun_d = overrun_q | ovr_evt;
    end
  end

  // Pending and overrun state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= 4'b0000;
      overrun_q <= 4'b0000;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  assign x       = pending_q;
  assign overrun = overrun_q;

endmodule
